// File: rtl/exec_wb_pipe.sv
// ----------------------------------------------------------------------------
// exec_wb_pipe
//
// Execute-to-writeback slice of the 5-stage CPU datapath. Register-file
// operands are captured into the EX register and evaluated by the ALU. The
// ALU result then moves through the memory-stage register (mem_addr) and the
// writeback register (dw). Condition flags are registered alongside mem_addr
// and update only for flag-setting operations.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous reset, active low (0 = reset)
//   da         in   operand A (register-file read port 1)
//   alu_b      in   operand B (Db or zero-extended Imm12, already muxed)
//   cntrl      in   ALU operation code
//   flag_en    in   1 = operation updates the condition flags
//   mem_addr   out  registered ALU result, memory stage
//   dw         out  registered writeback data
//   negative   out  registered N flag
//   zero       out  registered Z flag
//   overflow   out  registered V flag
//   carry_out  out  registered C flag
//
// ALU operation codes
//   000  pass B
//   010  A + B
//   011  A - B   (A + ~B + 1)
//   100  A & B
//   101  A | B
//   110  A ^ B
//   001, 111  zero
// ----------------------------------------------------------------------------
module exec_wb_pipe #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] da,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [2:0]       cntrl,
    input  logic             flag_en,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] dw,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    localparam logic [2:0] OP_PASS_B = 3'b000;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b011;
    localparam logic [2:0] OP_AND    = 3'b100;
    localparam logic [2:0] OP_OR     = 3'b101;
    localparam logic [2:0] OP_XOR    = 3'b110;

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] ex_a_q,       ex_a_d;
    logic [WIDTH-1:0] ex_b_q,       ex_b_d;
    logic [2:0]       ex_cntrl_q,   ex_cntrl_d;
    logic             ex_flag_en_q, ex_flag_en_d;
    logic [WIDTH-1:0] mem_addr_q,   mem_addr_d;
    logic [WIDTH-1:0] dw_q,         dw_d;
    logic             flag_n_q,     flag_n_d;
    logic             flag_z_q,     flag_z_d;
    logic             flag_v_q,     flag_v_d;
    logic             flag_c_q,     flag_c_d;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic             is_sub;
    logic             is_arith;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] low_sum;
    logic             c_into_msb;
    logic             c_out_msb;
    logic             sum_msb;
    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] alu_res;
    logic             temp_n;
    logic             temp_z;
    logic             temp_v;
    logic             temp_c;

    always_comb begin
        is_sub   = (ex_cntrl_q == OP_SUB);
        is_arith = (ex_cntrl_q == OP_ADD) || is_sub;
        b_op     = is_sub ? ~ex_b_q : ex_b_q;

        // The adder is split below the MSB so the carry into bit WIDTH-1 is
        // visible: overflow is carry-in XOR carry-out of the top bit.
        low_sum    = {1'b0, ex_a_q[WIDTH-2:0]}
                   + {1'b0, b_op[WIDTH-2:0]}
                   + {{(WIDTH-1){1'b0}}, is_sub};
        c_into_msb = low_sum[WIDTH-1];
        sum_msb    = ex_a_q[WIDTH-1] ^ b_op[WIDTH-1] ^ c_into_msb;
        c_out_msb  = (ex_a_q[WIDTH-1] & b_op[WIDTH-1])
                   | (ex_a_q[WIDTH-1] & c_into_msb)
                   | (b_op[WIDTH-1]   & c_into_msb);
        add_res    = {sum_msb, low_sum[WIDTH-2:0]};

        case (ex_cntrl_q)
            OP_PASS_B: alu_res = ex_b_q;
            OP_ADD,
            OP_SUB:    alu_res = add_res;
            OP_AND:    alu_res = ex_a_q & ex_b_q;
            OP_OR:     alu_res = ex_a_q | ex_b_q;
            OP_XOR:    alu_res = ex_a_q ^ ex_b_q;
            default:   alu_res = '0;
        endcase

        temp_z = (alu_res == '0);
        temp_n = alu_res[WIDTH-1];
        temp_c = is_arith & c_out_msb;
        temp_v = is_arith & (c_into_msb ^ c_out_msb);
    end

    // ------------------------------------------------------------------
    // Next-state logic; reset clears every stage so in-flight results are
    // discarded rather than drained.
    // ------------------------------------------------------------------
    always_comb begin
        ex_a_d       = da;
        ex_b_d       = alu_b;
        ex_cntrl_d   = cntrl;
        ex_flag_en_d = flag_en;
        mem_addr_d   = alu_res;
        dw_d         = mem_addr_q;
        flag_n_d     = flag_n_q;
        flag_z_d     = flag_z_q;
        flag_v_d     = flag_v_q;
        flag_c_d     = flag_c_q;

        if (ex_flag_en_q) begin
            flag_n_d = temp_n;
            flag_z_d = temp_z;
            flag_v_d = temp_v;
            flag_c_d = temp_c;
        end

        if (!reset) begin
            ex_a_d       = '0;
            ex_b_d       = '0;
            ex_cntrl_d   = 3'b000;
            ex_flag_en_d = 1'b0;
            mem_addr_d   = '0;
            dw_d         = '0;
            flag_n_d     = 1'b0;
            flag_z_d     = 1'b0;
            flag_v_d     = 1'b0;
            flag_c_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        ex_a_q       <= ex_a_d;
        ex_b_q       <= ex_b_d;
        ex_cntrl_q   <= ex_cntrl_d;
        ex_flag_en_q <= ex_flag_en_d;
        mem_addr_q   <= mem_addr_d;
        dw_q         <= dw_d;
        flag_n_q     <= flag_n_d;
        flag_z_q     <= flag_z_d;
        flag_v_q     <= flag_v_d;
        flag_c_q     <= flag_c_d;
    end

    assign mem_addr  = mem_addr_q;
    assign dw        = dw_q;
    assign negative  = flag_n_q;
    assign zero      = flag_z_q;
    assign overflow  = flag_v_q;
    assign carry_out = flag_c_q;

endmodule

// File: tb/tb_exec_wb_pipe.sv
module tb_exec_wb_pipe;

    logic        clk;
    logic        reset;
    logic [63:0] da;
    logic [63:0] alu_b;
    logic [2:0]  cntrl;
    logic        flag_en;
    logic [63:0] mem_addr;
    logic [63:0] dw;
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        carry_out;

    int n_cmp;
    int n_err;

    exec_wb_pipe #(.WIDTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .da        (da),
        .alu_b     (alu_b),
        .cntrl     (cntrl),
        .flag_en   (flag_en),
        .mem_addr  (mem_addr),
        .dw        (dw),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic n, input logic z, input logic v, input logic c);
        check_val({tag, ".N"}, {63'd0, negative},  {63'd0, n});
        check_val({tag, ".Z"}, {63'd0, zero},      {63'd0, z});
        check_val({tag, ".V"}, {63'd0, overflow},  {63'd0, v});
        check_val({tag, ".C"}, {63'd0, carry_out}, {63'd0, c});
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op, input logic fe);
        da      = a;
        alu_b   = b;
        cntrl   = op;
        flag_en = fe;
    endtask

    task automatic idle();
        drive(64'd0, 64'd0, 3'b000, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        idle();
        #1;

        // Reset held for two edges with random operands present.
        for (int i = 0; i < 2; i++) begin
            drive({$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(7, 0)), 1'b1);
            tick();
        end
        check_val("rst.mem_addr", mem_addr, 64'd0);
        check_val("rst.dw", dw, 64'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);

        reset = 1'b1;
        idle();
        tick();
        check_val("post_rst.mem_addr", mem_addr, 64'd0);
        tick();
        check_val("post_rst.dw", dw, 64'd0);
        check_flags("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);

        // 5 + 7
        drive(64'd5, 64'd7, 3'b010, 1'b1);
        tick();
        idle();
        tick();
        check_val("add.mem_addr", mem_addr, 64'd12);
        check_flags("add", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_val("add.dw", dw, 64'd12);

        // 0x1234 - 0x1234, then 0 - 1 back-to-back
        drive(64'h1234, 64'h1234, 3'b011, 1'b1);
        tick();
        drive(64'd0, 64'd1, 3'b011, 1'b1);
        tick();
        check_val("sub_eq.mem_addr", mem_addr, 64'd0);
        check_flags("sub_eq", 1'b0, 1'b1, 1'b0, 1'b1);
        idle();
        tick();
        check_val("sub_borrow.mem_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
        check_val("sub_eq.dw", dw, 64'd0);
        check_flags("sub_borrow", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_val("sub_borrow.dw", dw, 64'hFFFF_FFFF_FFFF_FFFF);

        // Signed overflow, then unsigned wrap
        drive(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1'b1);
        tick();
        drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1'b1);
        tick();
        check_val("ovf.mem_addr", mem_addr, 64'h8000_0000_0000_0000);
        check_flags("ovf", 1'b1, 1'b0, 1'b1, 1'b0);
        idle();
        tick();
        check_val("wrap.mem_addr", mem_addr, 64'd0);
        check_flags("wrap", 1'b0, 1'b1, 1'b0, 1'b1);

        // Logic ops with flag_en=0: flags stay at Z=1 C=1
        drive(64'hF0, 64'h0F, 3'b100, 1'b0);
        tick();
        drive(64'hF0, 64'h0F, 3'b101, 1'b0);
        tick();
        drive(64'hDEAD, 64'hABC, 3'b000, 1'b0);
        tick();
        check_val("and.dw", dw, 64'd0);
        idle();
        tick();
        check_val("or.dw", dw, 64'hFF);
        tick();
        check_val("passb.dw", dw, 64'hABC);
        check_flags("hold", 1'b0, 1'b1, 1'b0, 1'b1);

        // XOR with flags: C/V forced to 0 for logic ops; code 111 yields 0
        drive(64'hFF, 64'h0F, 3'b110, 1'b1);
        tick();
        drive(64'h1234_5678, 64'h9ABC, 3'b111, 1'b0);
        tick();
        check_val("xor.mem_addr", mem_addr, 64'hF0);
        check_flags("xor", 1'b0, 1'b0, 1'b0, 1'b0);
        drive(64'h55, 64'h66, 3'b001, 1'b0);
        tick();
        check_val("op111.mem_addr", mem_addr, 64'd0);
        idle();
        tick();
        check_val("op001.mem_addr", mem_addr, 64'd0);

        // Set a nonzero flag state so reset clearing is observable
        drive(64'd0, 64'd1, 3'b011, 1'b1);
        tick();
        // Results 1, 2, 3 in flight, then reset for one edge
        drive(64'd0, 64'd1, 3'b010, 1'b0);
        tick();
        drive(64'd0, 64'd2, 3'b000, 1'b0);
        tick();
        drive(64'd5, 64'd2, 3'b011, 1'b0);
        tick();
        check_val("pre_rst.mem_addr", mem_addr, 64'd2);
        check_val("pre_rst.dw", dw, 64'd1);
        reset = 1'b0;
        idle();
        tick();
        check_val("mid_rst.mem_addr", mem_addr, 64'd0);
        check_val("mid_rst.dw", dw, 64'd0);
        check_flags("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("flush.mem_addr", mem_addr, 64'd0);
            check_val("flush.dw", dw, 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
